// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one external combinational ALU between two
// requesters: accept in IDLE, drive the ALU for one cycle in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] alu_data1_q, alu_data1_d;
    logic [WIDTH-1:0] alu_data2_q, alu_data2_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant;
    logic             idle;
    logic             accept;

    function automatic logic illegal_op(input logic [3:0] op);
        logic bad;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: bad = 1'b0;
            default:                       bad = 1'b1;
        endcase
        return bad;
    endfunction

    // A lone requester always wins; prio only breaks ties.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = prio_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign idle       = (state_q == IDLE);
    assign accept     = idle && (req0_valid || req1_valid);
    // Readies are masked while reset is held so nothing appears accepted then.
    assign req0_ready = rst_n && idle && req0_valid && !grant;
    assign req1_ready = rst_n && idle && req1_valid && grant;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        alu_data1_d  = alu_data1_q;
        alu_data2_d  = alu_data2_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_data1_d = grant ? req1_a  : req0_a;
                    alu_data2_d = grant ? req1_b  : req0_b;
                    alu_op_d    = grant ? req1_op : req0_op;
                    rsp_id_d    = grant;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_err_d    = illegal_op(alu_op_q);
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    prio_d  = ~rsp_id_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_op_q     <= OP_AND;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            alu_data1_q  <= alu_data1_d;
            alu_data2_q  <= alu_data2_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_data1  = alu_data1_q;
    assign alu_data2  = alu_data2_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its alu_* ports.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [63:0] alu_data1, alu_data2, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [63:0] rsp_result;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Reference ALU: illegal codes return 0.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_data1 & alu_data2;
            4'b0001: alu_result = alu_data1 | alu_data2;
            4'b0010: alu_result = alu_data1 + alu_data2;
            4'b0110: alu_result = alu_data1 - alu_data2;
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge with that valid dropped.
    task automatic wait_ready(input string tag, input int id);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, found, 1'b1);
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    // Waits for the response, checks it, and lets it complete with rsp_ready=1.
    task automatic wait_rsp(input string tag, input logic id, input logic [63:0] res,
                            input logic z, input logic err);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_vld"}, found, 1'b1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_res"}, rsp_result, res);
        check({tag, "_zero"}, rsp_zero, z);
        check({tag, "_err"}, rsp_err, err);
        @(posedge clk); #1;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        // Reset held with both requesters valid.
        set_req(0, 64'h1234, 64'h0FF0, 4'b0000);
        set_req(1, 64'h0100, 64'h0001, 4'b0001);
        repeat (2) @(negedge clk);
        check("rst_alu_data1", alu_data1, 64'd0);
        check("rst_alu_data2", alu_data2, 64'd0);
        check("rst_alu_op", alu_op, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_rsp_zero", rsp_zero, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready("rst_first_acc", 0);
        wait_rsp("rst_first", 1'b0, 64'h0230, 1'b0, 1'b0);
        wait_ready("rst_second_acc", 1);
        wait_rsp("rst_second", 1'b1, 64'h0101, 1'b0, 1'b0);

        // Contention with prio=0.
        set_req(0, 64'd10, 64'd3, 4'b0110);
        set_req(1, 64'hF0, 64'h0F, 4'b0001);
        wait_ready("cont1_acc", 0);
        wait_rsp("cont1", 1'b0, 64'd7, 1'b0, 1'b0);
        wait_ready("cont2_acc", 1);
        wait_rsp("cont2", 1'b1, 64'hFF, 1'b0, 1'b0);

        // Single ADD with cycle-exact latency.
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
        @(negedge clk);
        check("add_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("add_ready_pulse", req0_ready, 1'b0);
        check("add_exec_vld", rsp_valid, 1'b0);
        check("add_exec_busy", busy, 1'b1);
        check("add_alu_data1", alu_data1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("add_vld", rsp_valid, 1'b1);
        check("add_res", rsp_result, 64'd0);
        check("add_zero", rsp_zero, 1'b1);
        check("add_id", rsp_id, 1'b0);
        check("add_err", rsp_err, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("add_done_vld", rsp_valid, 1'b0);
        check("add_done_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Third pair with prio=1: req1 first.
        set_req(0, 64'd100, 64'd23, 4'b0010);
        set_req(1, 64'd5, 64'd7, 4'b0110);
        wait_ready("pair3a_acc", 1);
        wait_rsp("pair3a", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        wait_ready("pair3b_acc", 0);
        wait_rsp("pair3b", 1'b0, 64'd123, 1'b0, 1'b0);

        // Illegal op from req1.
        set_req(1, 64'd5, 64'd5, 4'b1111);
        wait_ready("ill_acc", 1);
        wait_rsp("ill", 1'b1, 64'd0, 1'b1, 1'b1);

        // Backpressure: five stalled cycles in RESP with req1 waiting.
        rsp_ready = 1'b0;
        set_req(0, 64'hFF00, 64'h0FF0, 4'b0000);
        wait_ready("bp_acc", 0);
        set_req(1, 64'd1, 64'd2, 4'b0010);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld", rsp_valid, 1'b1);
            check("bp_res", rsp_result, 64'h0F00);
            check("bp_id", rsp_id, 1'b0);
            check("bp_rdy0", req0_ready, 1'b0);
            check("bp_rdy1", req1_ready, 1'b0);
            check("bp_busy", busy, 1'b1);
            check("bp_alu_hold", alu_data1, 64'hFF00);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_vld", rsp_valid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_done_vld", rsp_valid, 1'b0);
        check("bp_done_busy", busy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_dropped_req1", busy, 1'b0);
        @(posedge clk); #1;

        // Reset while in EXEC; prio is 1 going in.
        set_req(0, 64'd1, 64'd1, 4'b0010);
        wait_ready("rex_acc", 0);
        rst_n = 1'b0;
        #1;
        check("rex_busy", busy, 1'b0);
        check("rex_vld", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("rex_no_rsp", seen, 1'b0);
        check("rex_idle", busy, 1'b0);
        @(posedge clk); #1;

        // prio back to 0 after reset: req0 wins.
        set_req(0, 64'hA, 64'h5, 4'b0001);
        set_req(1, 64'd0, 64'h1234, 4'b0000);
        wait_ready("post_rst_acc0", 0);
        wait_rsp("post_rst0", 1'b0, 64'hF, 1'b0, 1'b0);
        wait_ready("post_rst_acc1", 1);
        wait_rsp("post_rst1", 1'b1, 64'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
